// File: rtl/llc_bus_responder_pkg.sv
// Shared encodings for the LLC system-bus agent: bus operations, snoop results,
// line geometry, responder FSM states and the snoop model used by the responder.
package llc_bus_responder_pkg;

  localparam logic [2:0] BUS_READ       = 3'd1;
  localparam logic [2:0] BUS_WRITE      = 3'd2;
  localparam logic [2:0] BUS_INVALIDATE = 3'd3;
  localparam logic [2:0] BUS_RWIM       = 3'd4;

  localparam int LINE_BYTES = 64;
  localparam int BUS_BYTES  = 8;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_result_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    WB,
    DATA,
    DONE
  } bus_state_t;

  // The other caches' snoop outcome is modelled from the two low address bits.
  function automatic snoop_result_t snoop_from_addr(input logic [1:0] addrLow);
    snoop_result_t res;
    case (addrLow)
      2'b00:   res = HIT;
      2'b01:   res = HITM;
      default: res = NOHIT;
    endcase
    return res;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == BUS_READ) || (op == BUS_WRITE) ||
           (op == BUS_INVALIDATE) || (op == BUS_RWIM);
  endfunction

endpackage

// File: rtl/llc_bus_responder_sat.sv
// Per-operation transaction counter that sticks at all-ones instead of wrapping.
module llc_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/llc_bus_responder.sv
// Bus-side agent for the LLC: accepts one transaction, reports the snoop result
// after a fixed latency, models an owner writeback when needed, streams the line
// data beats and acknowledges. Keeps saturating completion counts per operation.
module llc_bus_responder
  import llc_bus_responder_pkg::*;
#(
  parameter int SNOOP_LAT  = 2,
  parameter int LINE_BEATS = LINE_BYTES / BUS_BYTES,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_req,
  input  logic [2:0]       bus_op,
  input  logic [31:0]      bus_addr,
  output logic             snoop_valid,
  output logic [1:0]       snoop_result,
  output logic             data_valid,
  output logic             bus_ack,
  output logic             bus_busy,
  output logic             err_op,
  output logic             abort,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] rwim_cnt
);

  localparam int MAX_WAIT = (SNOOP_LAT > LINE_BEATS) ? SNOOP_LAT : LINE_BEATS;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] SNOOP_LAST = CW'(SNOOP_LAT - 1);
  localparam logic [CW-1:0] BEAT_LAST  = CW'(LINE_BEATS - 1);

  bus_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;

  logic          snoopValid_q, snoopValid_d;
  snoop_result_t snoopResult_q, snoopResult_d;
  logic          dataValid_q, dataValid_d;
  logic          busAck_q, busAck_d;
  logic          busBusy_q, busBusy_d;
  logic          errOp_q, errOp_d;
  logic          abort_q, abort_d;

  logic          abortHit;
  logic          needWb;
  logic          incRd, incWr, incInv, incRwim;
  logic          unusedAddrBits;

  // A writeback only happens when another cache holds the line modified and the
  // LLC is about to read it; a WRITE already owns the data it is sending.
  assign needWb = (snoop_from_addr(addr_q[1:0]) == HITM) &&
                  ((op_q == BUS_READ) || (op_q == BUS_RWIM));

  // Next-state logic: phase sequencing, shared latency/beat counter, abort detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    abortHit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_req) begin
          op_d    = bus_op;
          addr_d  = bus_addr;
          cnt_d   = '0;
          state_d = op_is_valid(bus_op) ? SNOOP : DONE;
        end
      end
      SNOOP: begin
        if (!bus_req) begin
          abortHit = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (cnt_q == SNOOP_LAST) begin
          cnt_d = '0;
          if (op_q == BUS_INVALIDATE) begin
            state_d = DONE;
          end else if (needWb) begin
            state_d = WB;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        if (!bus_req) begin
          abortHit = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (cnt_q == BEAT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (!bus_req) begin
          abortHit = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (cnt_q == BEAT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output next values; all pulses are registered so they appear the cycle after their cause.
  always_comb begin
    snoopValid_d  = (state_q == SNOOP) && (cnt_q == SNOOP_LAST) && bus_req;
    snoopResult_d = snoopValid_d ? snoop_from_addr(addr_q[1:0]) : snoopResult_q;
    dataValid_d   = (state_q == DATA) && bus_req;
    busAck_d      = (state_q == DONE);
    errOp_d       = (state_q == DONE) && !op_is_valid(op_q);
    abort_d       = abortHit;
    busBusy_d     = (state_d != IDLE);
  end

  // State, latched transaction and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      snoopValid_q  <= 1'b0;
      snoopResult_q <= NOHIT;
      dataValid_q   <= 1'b0;
      busAck_q      <= 1'b0;
      busBusy_q     <= 1'b0;
      errOp_q       <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      snoopValid_q  <= snoopValid_d;
      snoopResult_q <= snoopResult_d;
      dataValid_q   <= dataValid_d;
      busAck_q      <= busAck_d;
      busBusy_q     <= busBusy_d;
      errOp_q       <= errOp_d;
      abort_q       <= abort_d;
    end
  end

  // Counts step on the same edge that raises bus_ack; unknown ops count nowhere.
  assign incRd   = (state_q == DONE) && (op_q == BUS_READ);
  assign incWr   = (state_q == DONE) && (op_q == BUS_WRITE);
  assign incInv  = (state_q == DONE) && (op_q == BUS_INVALIDATE);
  assign incRwim = (state_q == DONE) && (op_q == BUS_RWIM);

  llc_sat_counter #(.CNT_W(CNT_W)) uRdCnt (
    .clk     (clk),
    .clear_i (!rst_n),
    .inc_i   (incRd),
    .count_o (rd_cnt)
  );

  llc_sat_counter #(.CNT_W(CNT_W)) uWrCnt (
    .clk     (clk),
    .clear_i (!rst_n),
    .inc_i   (incWr),
    .count_o (wr_cnt)
  );

  llc_sat_counter #(.CNT_W(CNT_W)) uInvCnt (
    .clk     (clk),
    .clear_i (!rst_n),
    .inc_i   (incInv),
    .count_o (inv_cnt)
  );

  llc_sat_counter #(.CNT_W(CNT_W)) uRwimCnt (
    .clk     (clk),
    .clear_i (!rst_n),
    .inc_i   (incRwim),
    .count_o (rwim_cnt)
  );

  // The full address is latched for the transaction record; only the low bits drive the snoop model.
  assign unusedAddrBits = ^addr_q[31:2];

  assign snoop_valid  = snoopValid_q;
  assign snoop_result = snoopResult_q;
  assign data_valid   = dataValid_q;
  assign bus_ack      = busAck_q;
  assign bus_busy     = busBusy_q;
  assign err_op       = errOp_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_llc_bus_responder.sv
// Directed scoreboard bench for llc_bus_responder: each transaction pushes its
// expected snoop/data/ack/abort events with edge numbers, a negedge monitor pops them.
module tb_llc_bus_responder;

  localparam int SNOOP_LAT  = 2;
  localparam int LINE_BEATS = 8;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam int EV_SNOOP = 1;
  localparam int EV_DATA  = 2;
  localparam int EV_ACK   = 3;
  localparam int EV_ABORT = 4;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_ABORT  = 1;
  localparam int MODE_RESET  = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] res;
    logic       err;
  } ev_t;

  ev_t sb[$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bus_req;
  logic [2:0]       bus_op;
  logic [31:0]      bus_addr;
  logic             snoop_valid;
  logic [1:0]       snoop_result;
  logic             data_valid;
  logic             bus_ack;
  logic             bus_busy;
  logic             err_op;
  logic             abort;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] inv_cnt;
  logic [CNT_W-1:0] rwim_cnt;

  int edgeNo         = 0;
  int vectorsApplied = 0;
  int miscompares    = 0;
  int expRd          = 0;
  int expWr          = 0;
  int expInv         = 0;
  int expRwim        = 0;

  llc_bus_responder #(
    .SNOOP_LAT  (SNOOP_LAT),
    .LINE_BEATS (LINE_BEATS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_req      (bus_req),
    .bus_op       (bus_op),
    .bus_addr     (bus_addr),
    .snoop_valid  (snoop_valid),
    .snoop_result (snoop_result),
    .data_valid   (data_valid),
    .bus_ack      (bus_ack),
    .bus_busy     (bus_busy),
    .err_op       (err_op),
    .abort        (abort),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt),
    .inv_cnt      (inv_cnt),
    .rwim_cnt     (rwim_cnt)
  );

  // Free-running clock and an edge index used to time-stamp every expected event.
  always #5 clk = ~clk;

  always @(posedge clk) edgeNo <= edgeNo + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorsApplied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, edgeNo);
    end
  endtask

  function automatic ev_t mkEv(input int kind, input int cyc, input logic [1:0] res, input logic err);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.res  = res;
    e.err  = err;
    return e;
  endfunction

  function automatic logic [1:0] expSnoop(input logic [31:0] a);
    logic [1:0] low;
    low = a[1:0];
    if (low == 2'b00) return 2'd1;
    if (low == 2'b01) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int satInc(input int x);
    return (x < CNT_MAX) ? x + 1 : x;
  endfunction

  // Pops the next expected event whenever the DUT raises one of its event outputs.
  task automatic popEvent(input int kind, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      checkOutput({"spurious ", name}, {28'd0, snoop_valid, data_valid, bus_ack, abort}, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({name, " kind"}, kind, e.kind);
      checkOutput({name, " edge"}, edgeNo, e.cyc);
      if (kind == EV_SNOOP) checkOutput("snoop_result", {30'd0, snoop_result}, {30'd0, e.res});
      if (kind == EV_ACK)   checkOutput("err_op", {31'd0, err_op}, {31'd0, e.err});
      if (kind == EV_ABORT) checkOutput("busy at abort", {31'd0, bus_busy}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (snoop_valid === 1'b1) popEvent(EV_SNOOP, "snoop_valid");
    if (data_valid === 1'b1)  popEvent(EV_DATA, "data_valid");
    if (bus_ack === 1'b1)     popEvent(EV_ACK, "bus_ack");
    if (abort === 1'b1)       popEvent(EV_ABORT, "abort");
  end

  task automatic waitEdge(input int target);
    while (edgeNo < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " rd_cnt"},   {30'd0, rd_cnt},   expRd);
    checkOutput({tag, " wr_cnt"},   {30'd0, wr_cnt},   expWr);
    checkOutput({tag, " inv_cnt"},  {30'd0, inv_cnt},  expInv);
    checkOutput({tag, " rwim_cnt"}, {30'd0, rwim_cnt}, expRwim);
  endtask

  // Drives one transaction, predicts its event timeline and waits for it to finish.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                               input int mode, input bit holdReq, input string tag);
    ev_t        plan[$];
    int         t0;
    int         cut;
    int         start;
    logic [1:0] r;
    bit         valid;
    bus_req  = 1'b1;
    bus_op   = op;
    bus_addr = addr;
    @(posedge clk);
    #1;
    t0 = edgeNo;
    checkOutput({tag, " busy after accept"}, {31'd0, bus_busy}, 32'd1);
    r     = expSnoop(addr);
    valid = (op >= 3'd1) && (op <= 3'd4);
    if (!valid) begin
      plan.push_back(mkEv(EV_ACK, t0 + 1, 2'd0, 1'b1));
    end else begin
      plan.push_back(mkEv(EV_SNOOP, t0 + SNOOP_LAT, r, 1'b0));
      if (op == 3'd3) begin
        plan.push_back(mkEv(EV_ACK, t0 + SNOOP_LAT + 1, 2'd0, 1'b0));
      end else begin
        start = t0 + SNOOP_LAT + 1 + (((r == 2'd2) && (op != 3'd2)) ? LINE_BEATS : 0);
        for (int b = 0; b < LINE_BEATS; b++) plan.push_back(mkEv(EV_DATA, start + b, 2'd0, 1'b0));
        plan.push_back(mkEv(EV_ACK, start + LINE_BEATS, 2'd0, 1'b0));
      end
    end
    cut = (mode == MODE_NORMAL) ? plan[$].cyc : t0 + 4;
    foreach (plan[i]) if (plan[i].cyc <= cut) sb.push_back(plan[i]);
    if (mode == MODE_ABORT) sb.push_back(mkEv(EV_ABORT, t0 + 5, 2'd0, 1'b0));
    waitEdge(cut);
    if (mode == MODE_NORMAL) begin
      @(negedge clk);
      #1;
      if (!holdReq) bus_req = 1'b0;
      if (op == 3'd1) expRd   = satInc(expRd);
      if (op == 3'd2) expWr   = satInc(expWr);
      if (op == 3'd3) expInv  = satInc(expInv);
      if (op == 3'd4) expRwim = satInc(expRwim);
    end else if (mode == MODE_ABORT) begin
      bus_req = 1'b0;
      waitEdge(t0 + 5);
      @(negedge clk);
      #1;
    end else begin
      rst_n   = 1'b0;
      bus_req = 1'b0;
      waitEdge(t0 + 5);
      @(negedge clk);
      #1;
      checkOutput({tag, " outputs in reset"},
                  {25'd0, snoop_valid, data_valid, bus_ack, bus_busy, err_op, abort, snoop_result}, 32'd0);
      expRd   = 0;
      expWr   = 0;
      expInv  = 0;
      expRwim = 0;
      rst_n   = 1'b1;
    end
    checkOutput({tag, " scoreboard drained"}, sb.size(), 32'd0);
    checkOutput({tag, " busy at end"}, {31'd0, bus_busy}, 32'd0);
    checkCounters(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus_req  = 1'b0;
    bus_op   = 3'd0;
    bus_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs",
                {25'd0, snoop_valid, data_valid, bus_ack, bus_busy, err_op, abort, snoop_result}, 32'd0);
    checkCounters("reset");
    rst_n = 1'b1;

    applyStimulus(3'd1, 32'h0000_1002, MODE_NORMAL, 1'b0, "read nohit");
    applyStimulus(3'd4, 32'h0000_2001, MODE_NORMAL, 1'b0, "rwim hitm");
    applyStimulus(3'd3, 32'h0000_3000, MODE_NORMAL, 1'b0, "invalidate hit");
    applyStimulus(3'd0, 32'h0000_5000, MODE_NORMAL, 1'b0, "bad op 0");
    applyStimulus(3'd5, 32'h0000_5001, MODE_NORMAL, 1'b0, "bad op 5");
    applyStimulus(3'd1, 32'h0000_1002, MODE_ABORT,  1'b0, "read abort");
    applyStimulus(3'd1, 32'h0000_6002, MODE_RESET,  1'b0, "read reset");
    applyStimulus(3'd2, 32'h0000_7003, MODE_NORMAL, 1'b0, "write after reset");
    applyStimulus(3'd2, 32'h0000_4001, MODE_NORMAL, 1'b1, "b2b write 1");
    applyStimulus(3'd2, 32'h0000_4000, MODE_NORMAL, 1'b1, "b2b write 2");
    applyStimulus(3'd2, 32'h0000_4002, MODE_NORMAL, 1'b0, "b2b write 3");

    repeat (4) @(posedge clk);
    #1;
    checkOutput("final scoreboard", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
